sync_fifo_cfg: RTL and testbench

- Parametrised single-clock FIFO; successor to the team's fixed synchronous FIFO.
- Adds a compile-time standard/FWFT mode and arbitrary (non-power-of-2) depth.
- Adds runtime almost-full/almost-empty thresholds, plus sticky overflow/underflow flags with clear.
- Sits between producer/consumer stages on one clock domain.

---
 rtl/sync_fifo_pkg.sv | 12 +
 rtl/sync_fifo_cfg_ram.sv | 40 ++++
 rtl/sync_fifo_cfg.sv | 118 +++++++++++
 tb/tb_sync_fifo_cfg.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared constants and helpers for the configurable synchronous FIFO.
package sync_fifo_pkg;

  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  // Width needed to hold a count of 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sync_fifo_cfg_ram.sv
// Simple dual-port storage array: synchronous write, registered or
// asynchronous read selected at elaboration time.
module fifo_ram #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 32,
  parameter int REG_RD = 1,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage write; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  generate
    if (REG_RD != 0) begin : g_reg
      // Registered read port: updates only on a read, holds otherwise.
      always_ff @(posedge clk) begin
        if (rst)     rdata <= '0;
        else if (re) rdata <= mem[raddr];
      end
    end else begin : g_async
      assign rdata = mem[raddr];
      logic unused_rd;
      assign unused_rd = ^{rst, re};
    end
  endgenerate

endmodule

// File: rtl/sync_fifo_cfg.sv
// Configurable single-clock FIFO: arbitrary depth, standard or FWFT read,
// runtime almost-full/almost-empty thresholds, overflow/underflow flags.
module sync_fifo_cfg
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 32,
  parameter int FWFT  = FIFO_MODE_STD,
  parameter int CNT_W = cnt_width(DEPTH)
) (
  input  logic             i_CLK,
  input  logic             i_RESET,
  input  logic             i_WR_EN,
  input  logic [WIDTH-1:0] i_WR_DATA,
  output logic             o_FULL,
  output logic             o_ALMOST_FULL,
  input  logic             i_RD_EN,
  output logic [WIDTH-1:0] o_RD_DATA,
  output logic             o_VALID,
  output logic             o_EMPTY,
  output logic             o_ALMOST_EMPTY,
  output logic [CNT_W-1:0] o_COUNT,
  input  logic [CNT_W-1:0] i_AF_THRESH,
  input  logic [CNT_W-1:0] i_AE_THRESH,
  output logic             o_OF,
  output logic             o_UF,
  output logic             o_OF_STICKY,
  output logic             o_UF_STICKY,
  input  logic             i_CLR_FLAGS
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             rd_acc, wr_acc;
  logic [WIDTH-1:0] ram_q;

  // Pointers wrap by compare so non power-of-2 depths work.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign o_EMPTY        = (count == '0);
  assign o_FULL         = (count == CNT_W'(DEPTH));
  assign o_ALMOST_FULL  = (count >= i_AF_THRESH);
  assign o_ALMOST_EMPTY = (count <= i_AE_THRESH);
  assign o_COUNT        = count;

  // A write at full slips in only when a read frees the slot this cycle.
  assign rd_acc = i_RD_EN & ~o_EMPTY;
  assign wr_acc = i_WR_EN & (~o_FULL | rd_acc);

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge i_CLK) begin
    if (i_RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= ptr_inc(wr_ptr);
      if (rd_acc) rd_ptr <= ptr_inc(rd_ptr);
      if (wr_acc & ~rd_acc)      count <= count + CNT_W'(1);
      else if (rd_acc & ~wr_acc) count <= count - CNT_W'(1);
    end
  end

  // Error pulses plus sticky copies; a new event beats a same-cycle clear.
  always_ff @(posedge i_CLK) begin
    if (i_RESET) begin
      o_OF        <= 1'b0;
      o_UF        <= 1'b0;
      o_OF_STICKY <= 1'b0;
      o_UF_STICKY <= 1'b0;
    end else begin
      o_OF <= i_WR_EN & ~wr_acc;
      o_UF <= i_RD_EN & ~rd_acc;
      if (i_WR_EN & ~wr_acc) o_OF_STICKY <= 1'b1;
      else if (i_CLR_FLAGS)  o_OF_STICKY <= 1'b0;
      if (i_RD_EN & ~rd_acc) o_UF_STICKY <= 1'b1;
      else if (i_CLR_FLAGS)  o_UF_STICKY <= 1'b0;
    end
  end

  fifo_ram #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .REG_RD ((FWFT == FIFO_MODE_FWFT) ? 0 : 1),
    .AW     (AW)
  ) u_ram (
    .clk   (i_CLK),
    .rst   (i_RESET),
    .we    (wr_acc & ~i_RESET),
    .waddr (wr_ptr),
    .wdata (i_WR_DATA),
    .re    (rd_acc & ~i_RESET),
    .raddr (rd_ptr),
    .rdata (ram_q)
  );

  generate
    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
      // Head word is always presented; zero while empty.
      assign o_VALID   = ~o_EMPTY;
      assign o_RD_DATA = o_EMPTY ? '0 : ram_q;
    end else begin : g_std
      logic rd_vld;
      // Valid marks the single cycle after an accepted read.
      always_ff @(posedge i_CLK) begin
        if (i_RESET) rd_vld <= 1'b0;
        else         rd_vld <= rd_acc;
      end
      assign o_VALID   = rd_vld;
      assign o_RD_DATA = ram_q;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_cfg.sv
// Bench for sync_fifo_cfg: a 32-deep standard FIFO and a 24-deep FWFT FIFO
// share one stimulus stream and are checked against queue-based models.
module tb_sync_fifo_cfg;

  logic       clk = 1'b0;
  logic       rst = 1'b0, wr = 1'b0, rd = 1'b0, clr = 1'b0;
  logic [7:0] din = '0;
  logic [5:0] af0 = 6'd30, ae0 = 6'd2;
  logic [4:0] af1 = 5'd30, ae1 = 5'd2;

  logic [7:0] u0_rd, u1_rd;
  logic [5:0] u0_cnt;
  logic [4:0] u1_cnt;
  logic u0_full, u0_af, u0_vld, u0_emp, u0_ae, u0_of, u0_uf, u0_ofs, u0_ufs;
  logic u1_full, u1_af, u1_vld, u1_emp, u1_ae, u1_of, u1_uf, u1_ofs, u1_ufs;

  int checks = 0;
  int failures = 0;
  bit started = 0;

  always #5 clk = ~clk;

  sync_fifo_cfg #(.WIDTH(8), .DEPTH(32), .FWFT(0)) u0 (
    .i_CLK(clk), .i_RESET(rst), .i_WR_EN(wr), .i_WR_DATA(din),
    .o_FULL(u0_full), .o_ALMOST_FULL(u0_af), .i_RD_EN(rd), .o_RD_DATA(u0_rd),
    .o_VALID(u0_vld), .o_EMPTY(u0_emp), .o_ALMOST_EMPTY(u0_ae), .o_COUNT(u0_cnt),
    .i_AF_THRESH(af0), .i_AE_THRESH(ae0), .o_OF(u0_of), .o_UF(u0_uf),
    .o_OF_STICKY(u0_ofs), .o_UF_STICKY(u0_ufs), .i_CLR_FLAGS(clr));

  sync_fifo_cfg #(.WIDTH(8), .DEPTH(24), .FWFT(1)) u1 (
    .i_CLK(clk), .i_RESET(rst), .i_WR_EN(wr), .i_WR_DATA(din),
    .o_FULL(u1_full), .o_ALMOST_FULL(u1_af), .i_RD_EN(rd), .o_RD_DATA(u1_rd),
    .o_VALID(u1_vld), .o_EMPTY(u1_emp), .o_ALMOST_EMPTY(u1_ae), .o_COUNT(u1_cnt),
    .i_AF_THRESH(af1), .i_AE_THRESH(ae1), .o_OF(u1_of), .o_UF(u1_uf),
    .o_OF_STICKY(u1_ofs), .o_UF_STICKY(u1_ufs), .i_CLR_FLAGS(clr));

  // ---------------- reference model ----------------
  byte unsigned mq0[$], mq1[$];
  int m_dout[2];
  bit m_vld[2], m_of[2], m_uf[2], m_ofs[2], m_ufs[2];

  task automatic chk(input int k, input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL u%0d %s act=%0h exp=%0h t=%0t", k, nm, act, exp, $time);
    end
  endtask

  task automatic mstep(input int k, input int d, input byte unsigned qi[$], output byte unsigned qo[$]);
    byte unsigned q[$];
    bit racc, wacc;
    q = qi;
    if (rst) begin
      q.delete();
      m_dout[k] = 0; m_vld[k] = 0; m_of[k] = 0; m_uf[k] = 0; m_ofs[k] = 0; m_ufs[k] = 0;
    end else begin
      racc = rd && (q.size() != 0);
      wacc = wr && ((q.size() < d) || racc);
      m_vld[k] = 0;
      if (racc) begin m_dout[k] = int'(q.pop_front()); m_vld[k] = 1; end
      if (wacc) q.push_back(din);
      m_of[k] = wr && !wacc;
      m_uf[k] = rd && !racc;
      if (m_of[k]) m_ofs[k] = 1; else if (clr) m_ofs[k] = 0;
      if (m_uf[k]) m_ufs[k] = 1; else if (clr) m_ufs[k] = 0;
    end
    qo = q;
  endtask

  always @(posedge clk) begin
    mstep(0, 32, mq0, mq0);
    mstep(1, 24, mq1, mq1);
    if (rst) started = 1;
  end

  task automatic cmp(input int k, input bit fw, input int d, input byte unsigned q[$],
                     input logic [7:0] rdat, input logic vld, emp, ful, af, ae,
                     input logic [31:0] cnt, input logic of, uf, ofs, ufs,
                     input int afth, aeth);
    int n;
    n = q.size();
    chk(k, "count", cnt, n);
    chk(k, "empty", emp, n == 0);
    chk(k, "full", ful, n == d);
    chk(k, "almost_full", af, n >= afth);
    chk(k, "almost_empty", ae, n <= aeth);
    if (fw) begin
      chk(k, "valid", vld, n != 0);
      chk(k, "rd_data", rdat, (n != 0) ? q[0] : 8'h00);
    end else begin
      chk(k, "valid", vld, m_vld[k]);
      chk(k, "rd_data", rdat, m_dout[k]);
    end
    chk(k, "of", of, m_of[k]);
    chk(k, "uf", uf, m_uf[k]);
    chk(k, "of_sticky", ofs, m_ofs[k]);
    chk(k, "uf_sticky", ufs, m_ufs[k]);
  endtask

  // Every-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      cmp(0, 0, 32, mq0, u0_rd, u0_vld, u0_emp, u0_full, u0_af, u0_ae, 32'(u0_cnt),
          u0_of, u0_uf, u0_ofs, u0_ufs, int'(af0), int'(ae0));
      cmp(1, 1, 24, mq1, u1_rd, u1_vld, u1_emp, u1_full, u1_af, u1_ae, 32'(u1_cnt),
          u1_of, u1_uf, u1_ofs, u1_ufs, int'(af1), int'(ae1));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    rst = 1; step(); rst = 0;
    chk(0, "lit reset empty", u0_emp, 1'b1);
    chk(0, "lit reset ae", u0_ae, 1'b1);
    chk(0, "lit reset count", u0_cnt, 0);
    chk(1, "lit reset valid", u1_vld, 1'b0);
    chk(1, "lit reset rd_data", u1_rd, 8'h00);

    // Underflow on empty
    rd = 1; step(); rd = 0;
    chk(0, "lit uf pulse", u0_uf, 1'b1);
    chk(0, "lit uf sticky", u0_ufs, 1'b1);
    chk(0, "lit uf valid", u0_vld, 1'b0);
    step();
    chk(0, "lit uf pulse end", u0_uf, 1'b0);
    clr = 1; step(); clr = 0;
    chk(0, "lit uf sticky clr", u0_ufs, 1'b0);

    // Fill to full with thresholds 30/2
    for (int i = 0; i < 32; i++) begin
      wr = 1; din = 8'(8'h1A + i); step();
      if (i == 28) chk(0, "lit af at 29", u0_af, 1'b0);
      if (i == 29) chk(0, "lit af at 30", u0_af, 1'b1);
      if (i == 30) chk(0, "lit full at 31", u0_full, 1'b0);
    end
    chk(0, "lit full", u0_full, 1'b1);
    chk(0, "lit count full", u0_cnt, 32);
    din = 8'hFF; step(); wr = 0;
    chk(0, "lit of pulse", u0_of, 1'b1);
    chk(0, "lit count after of", u0_cnt, 32);

    // Drain in order
    rd = 1;
    for (int i = 0; i < 32; i++) begin
      step();
      chk(0, "lit drain data", u0_rd, 8'(8'h1A + i));
      chk(0, "lit drain valid", u0_vld, 1'b1);
      if (i == 28) chk(0, "lit ae at 3", u0_ae, 1'b0);
      if (i == 29) chk(0, "lit ae at 2", u0_ae, 1'b1);
    end
    rd = 0; step();
    chk(0, "lit drained empty", u0_emp, 1'b1);
    chk(0, "lit drained valid", u0_vld, 1'b0);
    chk(0, "lit drained no uf", u0_uf, 1'b0);

    // Simultaneous read/write while full
    for (int i = 0; i < 32; i++) begin wr = 1; din = 8'(8'h40 + i); step(); end
    rd = 1;
    for (int i = 0; i < 8; i++) begin
      din = 8'(i + 1); step();
      chk(0, "lit full rw count", u0_cnt, 32);
      chk(0, "lit full rw no of", u0_of, 1'b0);
    end
    wr = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (i == 0)  chk(0, "lit drain2 first", u0_rd, 8'h48);
      if (i == 24) chk(0, "lit drain2 new first", u0_rd, 8'h01);
      if (i == 31) chk(0, "lit drain2 new last", u0_rd, 8'h08);
    end
    rd = 0;

    // FWFT visibility and pop
    rst = 1; step(); rst = 0;
    wr = 1; din = 8'h65; step(); wr = 0;
    chk(1, "lit fwft valid", u1_vld, 1'b1);
    chk(1, "lit fwft data", u1_rd, 8'h65);
    rd = 1; step(); rd = 0;
    chk(1, "lit fwft popped valid", u1_vld, 1'b0);
    chk(1, "lit fwft popped empty", u1_emp, 1'b1);

    // Interleaved traffic to wrap the 24-deep pointers, then reset at count 10
    for (int i = 0; i < 60; i++) begin
      wr = 1; din = 8'(i); rd = (i >= 10); step();
    end
    chk(1, "lit wrap count", u1_cnt, 10);
    chk(1, "lit wrap head", u1_rd, 8'd50);
    rst = 1; step(); rst = 0; wr = 0; rd = 0;
    chk(1, "lit rst count", u1_cnt, 0);
    chk(1, "lit rst empty", u1_emp, 1'b1);
    chk(1, "lit rst of", u1_of, 1'b0);
    chk(1, "lit rst uf", u1_uf, 1'b0);

    // Randomized traffic with shifting bias, thresholds, clears and resets
    for (int i = 0; i < 3000; i++) begin
      int pw, pr;
      pw = ((i / 150) % 3 == 0) ? 80 : (((i / 150) % 3 == 1) ? 25 : 50);
      pr = 100 - pw;
      if (i % 200 == 0) begin
        af0 = 6'($urandom_range(0, 63)); ae0 = 6'($urandom_range(0, 63));
        af1 = 5'($urandom_range(0, 31)); ae1 = 5'($urandom_range(0, 31));
      end
      wr  = ($urandom_range(0, 99) < pw);
      rd  = ($urandom_range(0, 99) < pr);
      din = 8'($urandom);
      clr = ($urandom_range(0, 99) < 5);
      rst = ($urandom_range(0, 999) < 4);
      step();
    end
    wr = 0; rd = 0; clr = 0; rst = 0;
    step(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
